// File: rtl/tree_decoder_n_if.sv
// tree_decoder_n_if: packet in, optional select token, one-hot routed packet out.
// Latency: none (wires only).
// Backpressure: valid/ready on every channel; the select channel exists only with TREE_DECODER_SEL_EN.
interface tree_decoder_n_if #(
    parameter int W     = 9,
    parameter int SEL_W = 1
);
    localparam int NUM_OUT = 2**SEL_W;

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
`ifdef TREE_DECODER_SEL_EN
    logic               sel_valid;
    logic               sel_ready;
    logic [SEL_W-1:0]   sel_data;
`endif
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic [W-1:0]       out_data;

    // Upstream/downstream environment side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
`ifdef TREE_DECODER_SEL_EN
        , output sel_ready,
        input  sel_valid, sel_data
`endif
    );

    // Routing node side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
`ifdef TREE_DECODER_SEL_EN
        , input sel_ready,
        output sel_valid, sel_data
`endif
    );
endinterface

// File: rtl/tree_decoder_n.sv
// tree_decoder_n: tree NoC routing node; picks one of 2**SEL_W ports from the address digit (or leaf compare).
// Latency: accept->out_valid 2 cycles with TREE_DECODER_SEL_EN (select token in between), 1 cycle without.
// Backpressure: sel_ready/out_ready stall indefinitely, outputs held stable; in_ready overlaps the DATA handshake.
module tree_decoder_n #(
    parameter int              W         = 9,
    parameter int              ADDR_W    = 4,
    parameter int              SEL_W     = 1,
    parameter int              LEVEL     = 0,
    parameter int              LEAF      = 0,
    parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b1000,
    parameter logic [ADDR_W-1:0] MASK      = 4'b1000
) (
    input  logic            clk,
    input  logic            reset,
    tree_decoder_n_if.slave bus
);

`ifdef TREE_DECODER_SEL_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, SEL = 2'd1, DATA = 2'd2} state_t;
    // A freshly accepted packet first announces its port on the select channel.
    localparam state_t LOAD_ST = SEL;
`else
    typedef enum logic [1:0] {EMPTY = 2'd0, DATA = 2'd2} state_t;
    // Without the select channel a packet goes straight to delivery.
    localparam state_t LOAD_ST = DATA;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     pkt;
    logic [SEL_W-1:0] port;
    logic [SEL_W-1:0] port_nxt;
    logic             in_rdy;
    logic             accept;

    // Port is decided once, from the incoming packet, and held with it.
    generate
        if (LEAF != 0) begin : g_leaf
            assign port_nxt = ((bus.in_data[W-1 -: ADDR_W] & MASK) == NODE_ADDR)
                              ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
        end else begin : g_digit
            assign port_nxt = bus.in_data[W-1-LEVEL*SEL_W -: SEL_W];
        end
    endgenerate

    // Ready when empty, or when the held packet leaves this very cycle.
    always_comb begin
        in_rdy = (state == EMPTY) || ((state == DATA) && bus.out_ready[port]);
        accept = bus.in_valid && in_rdy;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Holding registers load only on accept, so they stay stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt  <= '0;
            port <= '0;
        end else if (accept) begin
            pkt  <= bus.in_data;
            port <= port_nxt;
        end
    end

    // Next-state: an accept during DATA takes priority over going empty.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) state_nxt = LOAD_ST;
            end
`ifdef TREE_DECODER_SEL_EN
            SEL: begin
                if (bus.sel_ready) state_nxt = DATA;
            end
`endif
            DATA: begin
                if (accept) begin
                    state_nxt = LOAD_ST;
                end else if (bus.out_ready[port]) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Outputs decoded from registered state; only in_ready sees out_ready combinationally.
    always_comb begin
        bus.in_ready  = in_rdy;
        bus.out_valid = '0;
        if (state == DATA) begin
            bus.out_valid[port] = 1'b1;
        end
        bus.out_data  = pkt;
`ifdef TREE_DECODER_SEL_EN
        bus.sel_valid = (state == SEL);
        bus.sel_data  = port;
`endif
    end

endmodule

// File: tb/tb_tree_decoder_n.sv
module tb_tree_decoder_n;

`ifdef TREE_DECODER_SEL_EN
    localparam int LAT        = 2;
    localparam int STREAM_CYC = 17;
`else
    localparam int LAT        = 1;
    localparam int STREAM_CYC = 9;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tree_decoder_n_if #(.W(9), .SEL_W(1)) bus ();
    tree_decoder_n_if #(.W(9), .SEL_W(1)) lbus ();
    tree_decoder_n_if #(.W(9), .SEL_W(2)) qbus ();

    tree_decoder_n #(.W(9), .ADDR_W(4), .SEL_W(1), .LEVEL(0), .LEAF(0))
        dut (.clk(clk), .reset(reset), .bus(bus));
    tree_decoder_n #(.W(9), .ADDR_W(4), .SEL_W(1), .LEVEL(0), .LEAF(1),
                     .NODE_ADDR(4'b1000), .MASK(4'b1100))
        dut_leaf (.clk(clk), .reset(reset), .bus(lbus));
    tree_decoder_n #(.W(9), .ADDR_W(4), .SEL_W(2), .LEVEL(1), .LEAF(0))
        dut_quad (.clk(clk), .reset(reset), .bus(qbus));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none (cycle %0d)", name, act, cyc);
    endtask

    // Reference: address is the top 4 bits; digit LEVEL counted from the MSB end.
    function automatic int model_port(input logic [8:0] d, input int sel_w, input int level,
                                      input bit leaf, input int mask, input int node);
        int addr;
        int n;
        addr = int'(d) / 32;
        n    = 1 << sel_w;
        if (leaf) return ((addr & mask) == node) ? 0 : n - 1;
        return (addr / (1 << (4 - (level + 1) * sel_w))) % n;
    endfunction

    typedef struct {
        logic [8:0] d;
        int         p;
        int         acc;
        bit         lat;
    } ent_t;

    ent_t       exp_q[$];
    int         sel_q[$];
    bit         lat_mode = 1'b0;
    int         n_del    = 0;
    int         last_del = 0;
    bit         prev_ostall = 1'b0;
    logic [1:0] prev_ov;
    logic [8:0] prev_od;
    ent_t       mon_e;
    int         mon_p;
`ifdef TREE_DECODER_SEL_EN
    bit         prev_sstall = 1'b0;
    logic       prev_sd;
`endif

    // Monitor / scoreboard for the main instance.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            sel_q.delete();
            prev_ostall = 1'b0;
`ifdef TREE_DECODER_SEL_EN
            prev_sstall = 1'b0;
`endif
        end else begin
            if (prev_ostall) begin
                chk("out_valid_stable", int'(bus.out_valid), int'(prev_ov));
                chk("out_data_stable", int'(bus.out_data), int'(prev_od));
            end
`ifdef TREE_DECODER_SEL_EN
            if (prev_sstall) begin
                chk("sel_valid_stable", int'(bus.sel_valid), 1);
                chk("sel_data_stable", int'(bus.sel_data), int'(prev_sd));
            end
            if (bus.sel_valid && bus.sel_ready) begin
                if (sel_q.size() == 0) begin
                    fail_now("sel_unexpected", int'(bus.sel_data));
                end else begin
                    mon_p = sel_q.pop_front();
                    chk("sel_data", int'(bus.sel_data), mon_p);
                end
            end
`endif
            if ((bus.out_valid & bus.out_ready) != 2'b00) begin
                if (exp_q.size() == 0) begin
                    fail_now("out_unexpected", int'(bus.out_data));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_valid_port", int'(bus.out_valid), 1 << mon_e.p);
                    chk("out_data", int'(bus.out_data), int'(mon_e.d));
                    if (mon_e.lat) chk("latency", cyc - mon_e.acc, LAT);
`ifdef TREE_DECODER_SEL_EN
                    chk("sel_before_data", sel_q.size(), 0);
`endif
                    n_del++;
                    last_del = cyc;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_e.d   = bus.in_data;
                mon_e.p   = model_port(bus.in_data, 1, 0, 1'b0, 0, 0);
                mon_e.acc = cyc;
                mon_e.lat = lat_mode;
                exp_q.push_back(mon_e);
                sel_q.push_back(mon_e.p);
            end
            prev_ostall = (bus.out_valid != 2'b00) && ((bus.out_valid & bus.out_ready) == 2'b00);
            prev_ov     = bus.out_valid;
            prev_od     = bus.out_data;
`ifdef TREE_DECODER_SEL_EN
            prev_sstall = bus.sel_valid && !bus.sel_ready;
            prev_sd     = bus.sel_data;
`endif
        end
    end

    // Random readiness while enabled.
    bit rnd_rdy = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) begin
                bus.out_ready = 2'($urandom_range(0, 3));
`ifdef TREE_DECODER_SEL_EN
                bus.sel_ready = 1'($urandom_range(0, 1));
`endif
            end
        end
    end

    // Present d until accepted; caller sits at posedge+1. Optionally leave in_valid high.
    task automatic send(input logic [8:0] d, input bit keep, output int acc);
        int n;
        n = 0;
        acc = -1;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) fail_now("send_timeout", int'(d));
        acc = cyc;
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_del(input int target, input int budget);
        int n;
        n = 0;
        while (n_del < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_del < target) fail_now("delivery_timeout", n_del);
    endtask

    task automatic probe_leaf(input logic [3:0] a);
        logic [8:0] d;
        int n;
        d = {a, 5'($urandom)};
        lbus.in_data  = d;
        lbus.in_valid = 1'b1;
        @(negedge clk);
        chk("leaf_in_ready", int'(lbus.in_ready), 1);
        @(posedge clk);
        #1;
        lbus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lbus.out_valid == 2'b00 && n < 8);
        chk("leaf_port", int'(lbus.out_valid), 1 << model_port(d, 1, 0, 1'b1, 4'b1100, 4'b1000));
        chk("leaf_data", int'(lbus.out_data), int'(d));
        chk("leaf_latency", n, LAT);
        @(posedge clk);
        #1;
    endtask

    task automatic probe_quad(input logic [3:0] a);
        logic [8:0] d;
        int n;
        d = {a, 5'($urandom)};
        qbus.in_data  = d;
        qbus.in_valid = 1'b1;
        @(negedge clk);
        chk("quad_in_ready", int'(qbus.in_ready), 1);
        @(posedge clk);
        #1;
        qbus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (qbus.out_valid == 4'b0000 && n < 8);
        chk("quad_port", int'(qbus.out_valid), 1 << model_port(d, 2, 1, 1'b0, 0, 0));
        chk("quad_data", int'(qbus.out_data), int'(d));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int first;
        int base;
        int n;
        bus.in_valid  = 1'b0;  bus.in_data  = '0;  bus.out_ready  = 2'b11;
        lbus.in_valid = 1'b0;  lbus.in_data = '0;  lbus.out_ready = 2'b11;
        qbus.in_valid = 1'b0;  qbus.in_data = '0;  qbus.out_ready = 4'b1111;
`ifdef TREE_DECODER_SEL_EN
        bus.sel_ready = 1'b1;  lbus.sel_ready = 1'b1;  qbus.sel_ready = 1'b1;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
`ifdef TREE_DECODER_SEL_EN
        chk("rst_sel_valid", int'(bus.sel_valid), 0);
        chk("rst_sel_data", int'(bus.sel_data), 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two packets to ports 0 and 1 with readies high.
        lat_mode = 1'b1;
        base = n_del;
        send(9'h0FF, 1'b0, acc);
        send(9'h100, 1'b0, acc);
        wait_del(base + 2, 50);
        lat_mode = 1'b0;

        // Leaf compare and 4-way digit routing.
        probe_leaf(4'b1011);
        probe_leaf(4'b0011);
        for (int i = 0; i < 4; i++) probe_leaf(4'($urandom));
        for (int i = 0; i < 4; i++) probe_quad(4'(i));
        for (int i = 0; i < 4; i++) probe_quad(4'($urandom));

        // Stalls: select token held, then selected output held.
`ifdef TREE_DECODER_SEL_EN
        bus.sel_ready = 1'b0;
`endif
        bus.out_ready = 2'b01;
        base = n_del;
        send(9'h1AB, 1'b0, acc);
`ifdef TREE_DECODER_SEL_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("selstall_in_ready", int'(bus.in_ready), 0);
            chk("selstall_sel_valid", int'(bus.sel_valid), 1);
            chk("selstall_sel_data", int'(bus.sel_data), 1);
            chk("selstall_out_valid", int'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;
        bus.sel_ready = 1'b1;
        @(posedge clk);
        #1;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("outstall_in_ready", int'(bus.in_ready), 0);
            chk("outstall_out_valid", int'(bus.out_valid), 2);
            chk("outstall_out_data", int'(bus.out_data), 9'h1AB);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 2'b11;
        wait_del(base + 1, 20);
        repeat (4) @(negedge clk);
        chk("stall_single_delivery", n_del, base + 1);
        @(posedge clk);
        #1;

        // Back-to-back stream of 8.
        lat_mode = 1'b1;
        base  = n_del;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            send(9'($urandom), (i < 7), acc);
            if (i == 0) first = acc;
        end
        wait_del(base + 8, 50);
        chk("stream_cycles", last_del - first + 1, STREAM_CYC);
        lat_mode = 1'b0;

        // Random traffic with random readies.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(9'($urandom), 1'b0, acc);
        end
        @(posedge clk);
        rnd_rdy = 1'b0;
        #1;
        bus.out_ready = 2'b11;
`ifdef TREE_DECODER_SEL_EN
        bus.sel_ready = 1'b1;
`endif
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("random_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset while a packet sits in DATA.
        bus.out_ready = 2'b00;
        send(9'h1F0, 1'b0, acc);
        n = 0;
        while (bus.out_valid == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pre_out_valid", int'(bus.out_valid), 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", int'(bus.out_valid), 0);
        chk("rst_mid_in_ready", int'(bus.in_ready), 1);
        reset = 1'b0;
        bus.out_ready = 2'b11;
        base = n_del;
        repeat (6) @(negedge clk);
        chk("rst_no_delivery", n_del, base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tree_decoder_n.md
# tree_decoder_n

Parametrised, clocked routing node for the tree network-on-chip. Accepts one packet at a time on a valid/ready input and extracts a destination port from the packet's address field. Emits the chosen port index on a select channel, then forwards the packet to exactly one of `NUM_OUT` output channels. Internal nodes route on one address digit chosen by tree level; leaf nodes compare the masked full address against the node address (local vs. upstream).

## Interface
- `W`, 9: packet width; the address field is `in_data[W-1 -: ADDR_W]`.
- `ADDR_W`, 4: address field width.
- `SEL_W`, 1: digit width; `NUM_OUT = 2**SEL_W` outputs.
- `LEVEL`, 0: tree level of this node. Legal when `(LEVEL+1)*SEL_W <= ADDR_W`.
- `LEAF`, 0: 1 selects leaf compare mode.
- `NODE_ADDR`, 4'b1000: leaf node address (`ADDR_W` bits).
- `MASK`, 4'b1000: leaf address mask (`ADDR_W` bits).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input packet valid.
- `in_ready`  out  1  input ready.
- `in_data`  in  W  input packet.
- `sel_valid`  out  1  select token valid (present only with `TREE_DECODER_SEL_EN`).
- `sel_ready`  in  1  select token accepted (present only with `TREE_DECODER_SEL_EN`).
- `sel_data`  out  SEL_W  chosen port index (present only with `TREE_DECODER_SEL_EN`).
- `out_valid`  out  NUM_OUT  one-hot per-port valid.
- `out_ready`  in  NUM_OUT  per-port ready.
- `out_data`  out  W  shared output bus; meaningful only where `out_valid` is set.

## Operation
- Holding register `pkt` (W bits) and port register `port` (SEL_W bits).
- FSM states: `EMPTY`, `SEL`, `DATA`.
- Port computation at accept, with `addr = in_data[W-1 -: ADDR_W]`:
  - `LEAF=0`: `port = addr[ADDR_W-1-LEVEL*SEL_W -: SEL_W]`.
  - `LEAF=1`: `port = 0` if `(addr & MASK) == NODE_ADDR`, else `port = NUM_OUT-1`.
- `in_ready = (state==EMPTY) || (state==DATA && out_ready[port])`.
- Accept (`in_valid && in_ready`) loads `pkt` and `port`, then goes to `SEL`.
- `SEL`: `sel_valid=1` and `sel_data=port`. On `sel_ready`, go to `DATA`.
- `DATA`: `out_valid[port]=1` and `out_data=pkt`; all other `out_valid` bits are 0.
  - On `out_ready[port]`, go to `EMPTY`.
  - If an accept happens in the same cycle, go to `SEL` with the new packet loaded.
- `out_ready` on unselected ports is ignored.
- Outputs never change while valid is high and ready is low. Data, port and valid are stable until the handshake completes.
- `sel` always completes before the corresponding `out_valid` asserts, so the token strictly precedes the data.

## Timing
- Reset state: `state=EMPTY`, `in_ready=1`, `sel_valid=0`, `sel_data=0`, `out_valid=0`, `out_data=0`, `pkt=0`, `port=0`.
- Reset asserted mid-packet discards the held packet. The next cycle shows reset values, and no partial handshakes are completed.
- All outputs are registered or decoded from registered state only, except `in_ready`, which depends combinationally on `out_ready[port]` in `DATA`.
- Latency with all readies held high:
  - accept at cycle 0;
  - `sel_valid` at cycle 1;
  - `out_valid` at cycle 2.
- Sustained throughput: 1 packet per 2 cycles. A new accept overlaps the `DATA` handshake.
- A backpressured `sel_ready` or `out_ready` stalls indefinitely with no loss and no duplication.

## Configuration
- Macro: `TREE_DECODER_SEL_EN`.
- Defined: the select channel ports exist and the FSM behaves as described above.
- Undefined:
  - the `sel_*` ports are removed and the `SEL` state is removed;
  - an accept goes directly to `DATA`, so `out_valid` asserts at cycle 1;
  - sustained throughput becomes 1 packet per cycle via the `DATA` overlap;
  - port computation and reset values are unchanged.

## Test plan
- Defaults, `LEAF=0`, `LEVEL=0`; send `9'h0FF` then `9'h100`, all readies high.
  - Required: `sel_data` 0 then 1.
  - Required: `out_valid` 2'b01 then 2'b10, each exactly 2 cycles after its accept.
  - Required: data unchanged.
- `LEAF=1`, `MASK=4'b1100`, `NODE_ADDR=4'b1000`; send address 4'b1011 and then 4'b0011.
  - Required: 4'b1011 goes to port 0; 4'b0011 goes to port 1.
- `SEL_W=2`, `ADDR_W=4`, `LEVEL=1`; send addresses 4'b0000, 4'b0001, 4'b0010 and 4'b0011.
  - Required: routed to ports 0, 1, 2 and 3 respectively.
- Hold `sel_ready=0` for 5 cycles, then `out_ready[1]=0` for 4 cycles.
  - Required: `in_ready=0` throughout both stalls.
  - Required: outputs stay stable.
  - Required: exactly one delivery after release.
- Back-to-back stream of 8 packets with readies high.
  - Required: 8 deliveries in 17 cycles.
  - Without `TREE_DECODER_SEL_EN`: 8 deliveries in 9 cycles.
- Assert `reset` in the `DATA` state.
  - Required: next cycle `out_valid=0` and `in_ready=1`.
  - Required: the held packet is never delivered.
